shift_frame_ctrl: RTL and testbench
===================================

SHIFT_FRAME_CTRL -- requirements
Module: shift_frame_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame, legal range 1..32.
REQ-002 Parameter STOP_BITS, default 1, number of stop-bit cycles, legal values 1 or 2.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port Rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_data  input  DATA_W  parallel word to serialise.
REQ-006 Port in_valid  input  1  in_data is valid.
REQ-007 Port in_ready  output  1  controller accepts a word this cycle.
REQ-008 Port abort  input  1  cancel the frame in progress.
REQ-009 Port serial_in  output  1  bit driven into the downstream siso chain; idle level 1.
REQ-010 Port shift_en  output  1  downstream siso chain shifts this cycle.
REQ-011 Port busy  output  1  frame in progress (state != IDLE).
REQ-012 Port done  output  1  one-cycle pulse on the final stop-bit cycle.

Function
REQ-013 States SHALL be IDLE, START, DATA, PARITY (PARITY_EN only) and STOP; the encoding is free.
REQ-014 All outputs SHALL be registered, or decoded from registered state only.
REQ-015 In IDLE: in_ready=1, serial_in=1, shift_en=0, busy=0.
REQ-016 A handshake SHALL occur only when in_valid=1 and in_ready=1 at a rising edge.
- On a handshake, in_data is captured and the next state is START.
- in_valid while in_ready=0 SHALL be ignored; no word is captured.
REQ-017 START SHALL last 1 cycle: serial_in=0, shift_en=1.
REQ-018 DATA SHALL last exactly DATA_W cycles, LSB first.
- serial_in = captured bit[cnt]; shift_en=1.
- The bit counter is clog2(DATA_W) wide (minimum 1) and resets to 0 on entry to DATA.
- The counter wraps only on exit from DATA.
REQ-019 STOP SHALL last STOP_BITS cycles: serial_in=1, shift_en=1.
- done=1 on the last stop cycle only; the next state is IDLE.
REQ-020 Frame length SHALL be 1+DATA_W+P+STOP_BITS cycles, where P=1 with PARITY_EN and 0 without.
REQ-021 Back-to-back frames SHALL be separated by at least one IDLE cycle, the cycle in which the next handshake occurs.
REQ-022 in_ready SHALL be 0 in every non-IDLE state; data is never overwritten mid-frame.
REQ-023 abort=1 in any non-IDLE state SHALL return the FSM to IDLE at the next edge.
- serial_in=1 and shift_en=0 from that edge.
- done is not pulsed for the aborted frame.
REQ-024 abort=1 in IDLE SHALL block the handshake that cycle: in_ready is still 1, but the word is not accepted.
REQ-025 abort coinciding with the final stop cycle SHALL still yield done=1 in that cycle; the FSM returns to IDLE as normal.

Reset
REQ-026 Rst=1 at a rising edge SHALL force the following, from any state including mid-frame:
- state=IDLE and bit counter=0;
- serial_in=1, shift_en=0, busy=0, done=0, in_ready=1.
REQ-027 Rst SHALL take priority over abort and in_valid.
REQ-028 A handshake attempted in the same cycle as Rst SHALL be discarded.

Configuration
REQ-029 Macro SHIFT_FRAME_PARITY_EN controls the parity bit.
- Defined: the PARITY state (1 cycle) is inserted between DATA and STOP; serial_in = even parity (XOR of the captured word); shift_en=1.
- Undefined: there is no PARITY state and DATA proceeds directly to STOP.

Verification
REQ-030 The bench SHALL cover these directed scenarios (DATA_W=8, STOP_BITS=1 unless stated):
- 0xA5, no parity -> serial_in over 10 cycles = 0,1,0,1,0,0,1,0,1,1; done on cycle 10; in_ready again the cycle after.
- 0x07 with SHIFT_FRAME_PARITY_EN -> data bits 1,1,1,0,0,0,0,0, parity 1, stop 1; 11 shift_en cycles; 0xA5 gives parity 0.
- in_valid held high with words 0x01 then 0x80 -> two frames separated by exactly one IDLE cycle; 0x80 is not captured while busy.
- abort asserted on the 3rd DATA cycle of 0xFF -> IDLE next edge, serial_in=1, no done pulse; a following 0x3C frame is correct.
- Rst asserted on the 5th cycle of a frame -> all outputs at reset values next cycle; in_valid in the same cycle is not accepted.
- STOP_BITS=2 with 0x00 -> 8 zero data bits, 2 stop cycles; done only on the second stop cycle.

Source files
------------

// File: rtl/shift_frame_ctrl.sv
// Frame controller that serialises a parallel word as start/data/[parity]/stop bits into a siso chain.
// Define SHIFT_FRAME_PARITY_EN to insert an even-parity bit between the data and stop bits.
module shift_frame_ctrl #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              serial_in,
  output logic              shift_en,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic DONE_ON_ENTRY = (STOP_BITS == 1);

`ifdef SHIFT_FRAME_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] word;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              stop_cnt;

  assign cnt_nxt = cnt + CNT_W'(1);

  // Outputs are registered alongside the state: each transition loads the
  // output values belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stop_cnt  <= 1'b0;
      serial_in <= 1'b1;
      shift_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        // abort in IDLE vetoes the handshake even though in_ready is high
        if (in_valid && !abort) begin
          word      <= in_data;
          state     <= START;
          serial_in <= 1'b0;
          shift_en  <= 1'b1;
          busy      <= 1'b1;
          in_ready  <= 1'b0;
        end
      end else if (abort || (state == STOP && stop_cnt == STOP_LAST)) begin
        state     <= IDLE;
        cnt       <= '0;
        serial_in <= 1'b1;
        shift_en  <= 1'b0;
        busy      <= 1'b0;
        in_ready  <= 1'b1;
      end else begin
        case (state)
          START: begin
            state     <= DATA;
            cnt       <= '0;
            serial_in <= word[0];
          end
          DATA: begin
            if (cnt == LAST) begin
              cnt <= '0;
`ifdef SHIFT_FRAME_PARITY_EN
              state     <= PARITY;
              serial_in <= ^word;
`else
              state     <= STOP;
              stop_cnt  <= 1'b0;
              serial_in <= 1'b1;
              done      <= DONE_ON_ENTRY;
`endif
            end else begin
              cnt       <= cnt_nxt;
              serial_in <= word[cnt_nxt];
            end
          end
`ifdef SHIFT_FRAME_PARITY_EN
          PARITY: begin
            state     <= STOP;
            stop_cnt  <= 1'b0;
            serial_in <= 1'b1;
            done      <= DONE_ON_ENTRY;
          end
`endif
          STOP: begin
            // only reached with two stop bits: second stop cycle carries done
            stop_cnt <= 1'b1;
            done     <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Self-checking bench for shift_frame_ctrl: one-stop and two-stop instances share stimulus and
// are compared every cycle against a frame-position model; directed literal frames pin the model.
module tb_shift_frame_ctrl;

`ifdef SHIFT_FRAME_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       vld = 1'b0;
  logic       abrt = 1'b0;
  logic [1:0] rdy, ser, sh, bsy, dn;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_frame_ctrl #(.DATA_W(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .Rst(rst), .in_data(din), .in_valid(vld), .in_ready(rdy[0]),
    .abort(abrt), .serial_in(ser[0]), .shift_en(sh[0]), .busy(bsy[0]), .done(dn[0]));

  shift_frame_ctrl #(.DATA_W(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .Rst(rst), .in_data(din), .in_valid(vld), .in_ready(rdy[1]),
    .abort(abrt), .serial_in(ser[1]), .shift_en(sh[1]), .busy(bsy[1]), .done(dn[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a list of bits; an active frame is just a position in that list.
  logic m_busy [2];
  int   m_pos  [2];
  int   m_len  [2];
  logic m_frame [2][0:15];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_pos[k] = 0; m_len[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) m_busy[k] = 1'b0;
      else if (!m_busy[k]) begin
        if (vld && !abrt) begin
          int idx;
          m_frame[k][0] = 1'b0;
          for (int i = 0; i < 8; i++) m_frame[k][1+i] = din[i];
          idx = 9;
          if (P == 1) begin m_frame[k][idx] = ^din; idx++; end
          for (int s = 0; s <= k; s++) begin m_frame[k][idx] = 1'b1; idx++; end
          m_len[k] = idx; m_pos[k] = 0; m_busy[k] = 1'b1;
        end
      end else if (abrt || m_pos[k] == m_len[k] - 1) m_busy[k] = 1'b0;
      else m_pos[k]++;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_busy[k]) begin
        check($sformatf("serial_in%0d", k), 32'(ser[k]), 32'(m_frame[k][m_pos[k]]));
        check($sformatf("shift_en%0d", k), 32'(sh[k]), 32'd1);
        check($sformatf("busy%0d", k), 32'(bsy[k]), 32'd1);
        check($sformatf("in_ready%0d", k), 32'(rdy[k]), 32'd0);
        check($sformatf("done%0d", k), 32'(dn[k]), 32'(m_pos[k] == m_len[k] - 1));
      end else begin
        check($sformatf("idle_outs%0d", k), {27'd0, rdy[k], ser[k], sh[k], bsy[k], dn[k]}, 32'b11000);
      end
    end
  end

  // Inputs change at the negedge; after step returns, outputs reflect the edge that sampled them.
  task automatic step(input logic v, input logic [7:0] d, input logic a, input logic r);
    @(negedge clk);
    vld = v; din = d; abrt = a; rst = r;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  logic [15:0] sv, dv;
  int nshift, nzero;

  initial begin
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("reset_state", {27'd0, rdy[0], ser[0], sh[0], bsy[0], dn[0]}, 32'b11000);
    idle(2);

`ifndef SHIFT_FRAME_PARITY_EN
    // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1 with done on the tenth cycle
    sv = '0; dv = '0;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      sv[i] = ser[0]; dv[i] = dn[0];
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("a5_serial", 32'(sv), 32'b1101001010);
    check("a5_done", 32'(dv), 32'b1000000000);
    check("a5_ready_after", 32'(rdy[0]), 32'd1);
    idle(3);
`else
    // 0x07 with parity: start, 1,1,1,0,0,0,0,0, parity 1, stop
    sv = '0; nshift = 0;
    step(1'b1, 8'h07, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      sv[i] = ser[0]; nshift += int'(sh[0]);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("p07_serial", 32'(sv[10:0]), 32'b11000001110);
    check("p07_shift_cycles", 32'(nshift), 32'd11);
    idle(3);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("pa5_parity", 32'(ser[0]), 32'd0);
    idle(5);
`endif

    // in_valid held: 0x01 then 0x80, exactly one idle gap on the one-stop instance
    nzero = 0;
    step(1'b1, 8'h01, 1'b0, 1'b0);
    for (int i = 1; i <= 12 + P; i++) begin
      step(1'b1, 8'h80, 1'b0, 1'b0);
      if (bsy[0] == 1'b0) nzero++;
    end
    check("b2b_idle_gap", 32'(nzero), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    idle(14);

    // abort on the third DATA cycle of 0xFF, then a clean 0x3C frame
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("abort_outs", {27'd0, rdy[0], ser[0], sh[0], bsy[0], dn[0]}, 32'b11000);
    idle(2);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    idle(14);

    // abort while idle blocks the handshake
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("abort_idle_block", 32'(bsy[0]), 32'd0);
    idle(1);

    // reset on the fifth frame cycle, with in_valid high alongside
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    check("rst_mid_outs", {27'd0, rdy[0], ser[0], sh[0], bsy[0], dn[0]}, 32'b11000);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_mid_no_capture", 32'(bsy[0]), 32'd0);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_idle_no_capture", 32'(bsy[1]), 32'd0);
    idle(1);

    // two stop bits with 0x00: done only on the second stop cycle
    sv = '0; dv = '0;
    step(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 11 + P; i++) begin
      sv[i] = ser[1]; dv[i] = dn[1];
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
`ifdef SHIFT_FRAME_PARITY_EN
    check("s2_serial", 32'(sv), 32'b110000000000);
    check("s2_done", 32'(dv), 32'b100000000000);
`else
    check("s2_serial", 32'(sv), 32'b11000000000);
    check("s2_done", 32'(dv), 32'b10000000000);
`endif
    check("s2_ready_after", 32'(rdy[1]), 32'd1);
    idle(2);

    // random traffic with occasional abort and reset
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 150) == 0));
    end
    idle(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
